// File: rtl/i2s_pkg.sv
// i2s_pkg: framing constants and types shared by the
// i2s_player / i2s_receiver pair.
package i2s_pkg;

  localparam int I2S_SAMPLE_BITS = 16;
  localparam int I2S_SLOT_BITS   = 32;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    HUNT,
    LEFT,
    RIGHT
  } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: N-flop synchronizer for one edge-detected line plus
// side-band data carried through the same stages, with a rise pulse.
module sync_edge_detect #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [WIDTH:0]    stage [STAGES];
  logic [STAGES-1:0] fill;
  logic              lvl;
  logic              lvl_d;
  logic              primed;

  assign q      = stage[STAGES-1][WIDTH:1];
  assign lvl    = stage[STAGES-1][0];
  assign primed = fill[STAGES-1];
  assign rise   = primed & lvl & ~lvl_d;

  // Until the pipe holds real samples the delay flop reads high, so a
  // line already high at reset release must fall before it can rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        stage[i] <= '0;
      fill  <= '0;
      lvl_d <= 1'b1;
    end else begin
      stage[0] <= {d, sig};
      for (int i = 1; i < STAGES; i++)
        stage[i] <= stage[i-1];
      fill  <= {fill[STAGES-2:0], 1'b1};
      lvl_d <= lvl | ~primed;
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampled I2S deserializer; recovers left/right
// samples per 64-BCLK frame with slot-length checking.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = I2S_SAMPLE_BITS,
  parameter int SLOT_BITS   = I2S_SLOT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_12mhz,
  input  logic                          reset,
  input  logic                          i2s_bclk,
  input  logic                          i2s_lrck,
  input  logic                          i2s_din,
  output logic signed [SAMPLE_BITS-1:0] left_sample,
  output logic signed [SAMPLE_BITS-1:0] right_sample,
  output logic                          sample_valid,
  output logic                          frame_err,
  output logic                          locked
);

  localparam int CW = $clog2(SLOT_BITS + 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAMP = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(SLOT_BITS + 1);

  logic [1:0]             side;
  logic                   bclk_rise;
  logic                   lr;
  logic                   din;
  logic                   lr_prev;
  logic [CW-1:0]          bit_cnt;
  logic [SAMPLE_BITS-1:0] shift;
  logic [SAMPLE_BITS-1:0] hold;
  rx_state_t              state;
  rx_state_t              state_next;
  logic                   boundary;
  logic                   slot_ok;
  logic                   bad;
  logic                   load_hold;
  logic                   done;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES),
    .WIDTH (2)
  ) u_sync (
    .clk  (clk_12mhz),
    .reset(reset),
    .sig  (i2s_bclk),
    .d    ({i2s_din, i2s_lrck}),
    .q    (side),
    .rise (bclk_rise)
  );

  assign lr       = side[0];
  assign din      = side[1];
  assign boundary = bclk_rise & (lr != lr_prev);
  assign slot_ok  = (bit_cnt == CNT_SLOT);

  always_ff @(posedge clk_12mhz) begin
    if (reset)
      state <= HUNT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    bad        = 1'b0;
    load_hold  = 1'b0;
    done       = 1'b0;
    if (boundary) begin
      unique case (state)
        LEFT: begin
          if (!slot_ok) begin
            bad        = 1'b1;
            state_next = HUNT;
          end else begin
            load_hold  = 1'b1;
            state_next = RIGHT;
          end
        end
        RIGHT: begin
          if (!slot_ok) begin
            bad        = 1'b1;
            state_next = HUNT;
          end else begin
            done       = 1'b1;
            state_next = LEFT;
          end
        end
        default: begin
          if (!lr)
            state_next = LEFT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      lr_prev      <= 1'b0;
      bit_cnt      <= '0;
      shift        <= '0;
      hold         <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= done;
      frame_err    <= bad;
      if (bclk_rise) begin
        lr_prev <= lr;
        if (boundary) begin
          bit_cnt <= CNT_ONE;
          shift   <= {{(SAMPLE_BITS-1){1'b0}}, din};
        end else begin
          if (bit_cnt < CNT_SAMP)
            shift <= {shift[SAMPLE_BITS-2:0], din};
          // saturate so an overlong slot still fails at its boundary
          if (bit_cnt < CNT_SAT)
            bit_cnt <= bit_cnt + CNT_ONE;
        end
      end
      if (load_hold)
        hold <= shift;
      if (done) begin
        left_sample  <= hold;
        right_sample <= shift;
        locked       <= 1'b1;
      end
      if (bad)
        locked <= 1'b0;
    end
  end

endmodule
